// File: rtl/multdiv_stall_unit.sv
// Iterative signed multiply/divide for the execute stage: one bit per cycle on operand
// magnitudes, holding the pipeline via stall and handing back result, exception and tag.
module multdiv_stall_unit #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 5
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start_mult,
   input  logic             start_div,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic [TAG_W-1:0] tag_in,
   input  logic             flush,
   output logic             busy,
   output logic             stall,
   output logic             result_valid,
   output logic [WIDTH-1:0] result,
   output logic             exception,
   output logic [TAG_W-1:0] tag_out
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MULT = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t               state_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [2*WIDTH-1:0]   acc_q;
   logic [WIDTH-1:0]     opnd_q;
   logic                 neg_q;
   logic [TAG_W-1:0]     tag_q;

   logic                 accept;
   logic                 div_by_zero;
   logic [WIDTH-1:0]     a_mag;
   logic [WIDTH-1:0]     b_mag;
   logic [WIDTH:0]       mul_sum;
   logic [2*WIDTH-1:0]   mul_d;
   logic [WIDTH:0]       div_shift;
   logic [WIDTH:0]       div_trial;
   logic [2*WIDTH-1:0]   div_d;
   logic [2*WIDTH-1:0]   acc_d;
   logic [2*WIDTH-1:0]   prod_s;
   logic [WIDTH:0]       prod_top;
   logic [WIDTH-1:0]     quot_s;
   logic [WIDTH-1:0]     fin_result;
   logic                 fin_exc;

   // MIN maps to 2^(WIDTH-1), which is still exact as an unsigned magnitude.
   assign a_mag = op_a[WIDTH-1] ? (~op_a + 1'b1) : op_a;
   assign b_mag = op_b[WIDTH-1] ? (~op_b + 1'b1) : op_b;

   assign accept = ((state_q == S_IDLE) || (state_q == S_DONE)) &&
                   (start_mult ^ start_div) && !flush;
   assign stall  = busy | accept;

   assign div_by_zero = (state_q == S_DIV) && (opnd_q == '0);

   // Multiply: acc holds {partial product, remaining multiplier bits}, shifted right each step.
   assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
   assign mul_d   = {mul_sum, acc_q[WIDTH-1:1]};

   // Divide: acc holds {remainder, dividend/quotient}, restoring subtract each step.
   assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
   assign div_trial = div_shift - {1'b0, opnd_q};
   assign div_d     = div_trial[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                       : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

   assign acc_d = (state_q == S_DIV) ? div_d : mul_d;

   assign prod_s   = neg_q ? (~acc_d + 1'b1) : acc_d;
   assign prod_top = prod_s[2*WIDTH-1:WIDTH-1];
   assign quot_s   = neg_q ? (~acc_d[WIDTH-1:0] + 1'b1) : acc_d[WIDTH-1:0];

   always_comb begin
      fin_result = '0;
      fin_exc    = 1'b0;
      if (state_q == S_DIV) begin
         fin_result = quot_s;
         // A positive quotient of 2^(WIDTH-1) only arises from MIN / -1.
         fin_exc    = !neg_q && acc_d[WIDTH-1];
      end else begin
         fin_result = prod_s[WIDTH-1:0];
         fin_exc    = !((&prod_top) || !(|prod_top));
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         acc_q        <= '0;
         opnd_q       <= '0;
         neg_q        <= 1'b0;
         tag_q        <= '0;
         busy         <= 1'b0;
         result_valid <= 1'b0;
         result       <= '0;
         exception    <= 1'b0;
         tag_out      <= '0;
      end else begin
         result_valid <= 1'b0;
         if (flush) begin
            state_q <= S_IDLE;
            busy    <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE, S_DONE: begin
                  if (accept) begin
                     state_q <= start_div ? S_DIV : S_MULT;
                     busy    <= 1'b1;
                     cnt_q   <= '0;
                     neg_q   <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
                     tag_q   <= tag_in;
                     if (start_div) begin
                        opnd_q <= b_mag;
                        acc_q  <= {{WIDTH{1'b0}}, a_mag};
                     end else begin
                        opnd_q <= a_mag;
                        acc_q  <= {{WIDTH{1'b0}}, b_mag};
                     end
                  end else begin
                     state_q <= S_IDLE;
                  end
               end
               S_MULT, S_DIV: begin
                  if (div_by_zero) begin
                     state_q      <= S_DONE;
                     busy         <= 1'b0;
                     result_valid <= 1'b1;
                     result       <= '0;
                     exception    <= 1'b1;
                     tag_out      <= tag_q;
                  end else begin
                     acc_q <= acc_d;
                     cnt_q <= cnt_q + CNT_W'(1);
                     if (cnt_q == LAST_ITER) begin
                        state_q      <= S_DONE;
                        busy         <= 1'b0;
                        result_valid <= 1'b1;
                        result       <= fin_result;
                        exception    <= fin_exc;
                        tag_out      <= tag_q;
                     end
                  end
               end
               default: begin
                  state_q <= S_IDLE;
                  busy    <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
